// File: rtl/keypad_scan_debounce.sv
// Purpose: 4x4 hex keypad front end that scans, synchronizes and debounces, then locks onto a single key.
// Latency: rows are seen 2 clk after the pins; key_valid is registered and follows the last stable debounce sample.
// Backpressure: none. key_valid is a one-cycle pulse, and key_code holds its value until the next accept.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_scan_debounce #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int REPEAT_DELAY    = 5000,
    parameter int REPEAT_PERIOD   = 1000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_DONE   = DW'(DEBOUNCE_CYCLES);

    // Reject parameter sets the timing scheme cannot support.
    if (SCAN_DIV < 4) begin : g_chk_scan
        $error("SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_chk_rep
        $error("REPEAT_PERIOD must be in 1..REPEAT_DELAY");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      rs_meta, rs;
    logic [1:0]      col, col_nxt;
    logic [1:0]      row, row_nxt;
    logic [SW-1:0]   scan_cnt, scan_cnt_nxt;
    logic [DW-1:0]   db_cnt, db_cnt_nxt;
    logic [DW-1:0]   db_inc;
    logic [3:0]      key_code_nxt;
    logic            key_valid_nxt;
    logic            key_held_nxt;
    logic            any_low;
    logic [1:0]      low_idx;
    logic            row_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
    logic [RW-1:0]   rep_cnt, rep_cnt_nxt;
    logic [RW-1:0]   rep_inc;
    assign rep_inc = rep_cnt + RW'(1);
`endif

    // Hex code for each row/column crossing of the keypad.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Only one column is driven low at a time.
    assign col_n   = ~(4'b0001 << col);
    assign any_low = ~&rs;
    assign row_low = ~rs[row];
    assign db_inc  = (db_cnt == DB_DONE) ? db_cnt : db_cnt + DW'(1);
    assign low_idx = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;

    // Two-flop synchronizer for the asynchronous rows; idles at "no key pressed".
    always_ff @(posedge clk) begin
        if (nrst) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            rs_meta <= row_n;
            rs      <= rs_meta;
        end
    end

    // Next-state logic covers scanning, press debounce, hold and release debounce.
    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        scan_cnt_nxt  = scan_cnt;
        db_cnt_nxt    = db_cnt;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        key_held_nxt  = key_held;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_nxt   = '0;
`endif
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_nxt = '0;
                    if (any_low) begin
                        row_nxt    = low_idx;
                        db_cnt_nxt = '0;
                        state_nxt  = DB_PRESS;
                    end else begin
                        col_nxt = col + 2'd1;
                    end
                end else begin
                    scan_cnt_nxt = scan_cnt + SW'(1);
                end
            end
            DB_PRESS: begin
                if (row_low) begin
                    db_cnt_nxt = db_inc;
                    if (db_inc == DB_DONE) begin
                        key_code_nxt  = key_map(row, col);
                        key_valid_nxt = 1'b1;
                        key_held_nxt  = 1'b1;
                        db_cnt_nxt    = '0;
                        state_nxt     = HELD;
                    end
                end else begin
                    // The press did not survive debounce, so resume scanning at the next column.
                    col_nxt      = col + 2'd1;
                    scan_cnt_nxt = '0;
                    db_cnt_nxt   = '0;
                    state_nxt    = SCAN;
                end
            end
            HELD: begin
                if (!row_low) begin
                    db_cnt_nxt = '0;
                    state_nxt  = DB_REL;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt_nxt = rep_inc;
                    if (rep_inc == REP_FIRE) begin
                        key_valid_nxt = 1'b1;
                        rep_cnt_nxt   = REP_RELOAD;
                    end
`endif
                end
            end
            DB_REL: begin
                if (!row_low) begin
                    db_cnt_nxt = db_inc;
                    if (db_inc == DB_DONE) begin
                        key_held_nxt = 1'b0;
                        col_nxt      = col + 2'd1;
                        scan_cnt_nxt = '0;
                        db_cnt_nxt   = '0;
                        state_nxt    = SCAN;
                    end
                end else begin
                    // A release bounce returns to HELD; the key was already reported.
                    db_cnt_nxt = '0;
                    state_nxt  = HELD;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // State and datapath registers; reset discards any press that is still pending.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state     <= SCAN;
            col       <= 2'd0;
            row       <= 2'd0;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            scan_cnt  <= scan_cnt_nxt;
            db_cnt    <= db_cnt_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            key_held  <= key_held_nxt;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat timer runs only while in HELD and restarts whenever HELD is re-entered.
    always_ff @(posedge clk) begin
        if (nrst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce, using SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_DELAY=40 and REPEAT_PERIOD=10.
// A behavioural keypad model pulls a row low whenever a pressed key sits in the column that is being driven.
// Outputs are sampled on the falling edge of the clock.
module tb_keypad_scan_debounce;

    logic            clk;
    logic            nrst;
    logic [3:0]      row_n;
    logic [3:0]      col_n;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;
    logic [3:0][3:0] keys;   // keys[row][col] = 1 means pressed

    int n_checks;
    int n_fail;

    keypad_scan_debounce #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY   (40),
        .REPEAT_PERIOD  (10)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix model.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(keys[r] & ~col_n);
        end
    end

    task automatic sync_col(input logic [3:0] target, output bit ok);
        int k;
        k = 0;
        while (col_n === target && k < 40) begin @(negedge clk); k++; end
        while (col_n !== target && k < 80) begin @(negedge clk); k++; end
        ok = (col_n === target);
    endtask

    task automatic wait_pulse(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            @(negedge clk);
            if (key_valid) found = 1'b1;
        end
    endtask

    task automatic wait_held_low(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (!key_held) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        nrst = 1'b1;
        keys = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL reset_col_n: got %b expected 1110", col_n); end
        n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
        nrst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_col = 4'b1111;
            exp_col[(i / 4) % 4] = 1'b0;
            n_checks++;
            if (col_n !== exp_col) begin
                n_fail++; $display("FAIL scan_seq[%0d]: got %b expected %b", i, col_n, exp_col);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clean_press();
        bit ok;
        int k;
        int lat;
        int pulses;
        int bad;
        sync_col(4'b1110, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL press_sync: got timeout expected col 0"); end
        keys[1][2] = 1'b1;   // key '6'
        k = 0;
        while (col_n !== 4'b1011 && k < 40) begin @(negedge clk); k++; end
        n_checks++; if (col_n !== 4'b1011) begin n_fail++; $display("FAIL press_col2: got %b expected 1011", col_n); end
        lat = 0;
        while (!key_valid && lat < 40) begin @(negedge clk); lat++; end
        n_checks++; if (lat != 12) begin n_fail++; $display("FAIL press_latency: got %0d expected 12", lat); end
        n_checks++; if (key_code !== 4'h6) begin n_fail++; $display("FAIL press_code: got %h expected 6", key_code); end
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL press_held: got %b expected 1", key_held); end
        @(negedge clk);
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL press_pulse_width: got %b expected 0", key_valid); end
        pulses = 0;
        repeat (20) begin @(negedge clk); if (key_valid) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL press_extra_pulse: got %0d expected 0", pulses); end
        keys = '0;
        bad = 0;
        for (int i = 1; i <= 10; i++) begin @(negedge clk); if (key_held !== 1'b1) bad++; end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL release_held_early: got %0d drops expected 0", bad); end
        @(negedge clk);
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL release_held: got %b expected 0", key_held); end
        n_checks++; if (col_n !== 4'b0111) begin n_fail++; $display("FAIL release_col: got %b expected 0111", col_n); end
    endtask

    task automatic test_bounce();
        bit ok;
        int pulses;
        int drops;
        sync_col(4'b1110, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bounce_sync: got timeout expected col 0"); end
        keys[0][0] = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (key_valid) pulses++;
            if (i == 7) keys = '0;
            if (i == 9) begin
                n_checks++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL bounce_col_hold: got %b expected 1110", col_n); end
            end
            if (i == 10) begin
                n_checks++; if (col_n !== 4'b1101) begin n_fail++; $display("FAIL bounce_col_adv: got %b expected 1101", col_n); end
            end
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL bounce_press_pulse: got %0d expected 0", pulses); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL bounce_press_held: got %b expected 0", key_held); end
        // Release bounce while in DB_REL.
        keys[0][0] = 1'b1;
        wait_pulse(60, ok);
        n_checks++; if (!ok || key_code !== 4'h1) begin n_fail++; $display("FAIL rel_bounce_accept: got %b/%h expected 1/1", ok, key_code); end
        @(negedge clk);
        keys = '0;
        repeat (5) @(negedge clk);
        keys[0][0] = 1'b1;
        pulses = 0;
        drops = 0;
        repeat (30) begin
            @(negedge clk);
            if (key_valid) pulses++;
            if (!key_held) drops++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rel_bounce_pulse: got %0d expected 0", pulses); end
        n_checks++; if (drops != 0) begin n_fail++; $display("FAIL rel_bounce_held: got %0d drops expected 0", drops); end
        keys = '0;
        wait_held_low(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rel_bounce_release: got held expected released"); end
    endtask

    task automatic test_two_keys();
        bit ok;
        int pulses;
        keys[0][0] = 1'b1;   // '1'
        wait_pulse(60, ok);
        n_checks++; if (!ok || key_code !== 4'h1) begin n_fail++; $display("FAIL two_first: got %b/%h expected 1/1", ok, key_code); end
        keys[1][1] = 1'b1;   // '5'
        pulses = 0;
        repeat (30) begin @(negedge clk); if (key_valid) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL two_second_ignored: got %0d expected 0", pulses); end
        n_checks++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL two_held: got %b expected 1", key_held); end
        keys[0][0] = 1'b0;
        wait_pulse(80, ok);
        n_checks++; if (!ok || key_code !== 4'h5) begin n_fail++; $display("FAIL two_redetect: got %b/%h expected 1/5", ok, key_code); end
        keys = '0;
        wait_held_low(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL two_release: got held expected released"); end
    endtask

    task automatic test_reset_mid_press();
        bit ok;
        int pulses;
        sync_col(4'b1110, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_sync: got timeout expected col 0"); end
        keys[0][0] = 1'b1;
        repeat (9) @(negedge clk);
        n_checks++; if (key_code !== 4'h5 || key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre: got %h/%b expected 5/0", key_code, key_valid); end
        nrst = 1'b1;
        keys = '0;
        @(negedge clk);
        n_checks++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL rst_mid_col: got %b expected 1110", col_n); end
        n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL rst_mid_code: got %h expected 0", key_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", key_valid); end
        n_checks++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rst_mid_held: got %b expected 0", key_held); end
        @(negedge clk);
        nrst = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (key_valid) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_pulse: got %0d expected 0", pulses); end
    endtask

    task automatic test_repeat();
        bit ok;
        bit exp_p;
        int bad;
        keys[3][3] = 1'b1;   // 'D'
        wait_pulse(80, ok);
        n_checks++; if (!ok || key_code !== 4'hD) begin n_fail++; $display("FAIL repeat_accept: got %b/%h expected 1/d", ok, key_code); end
        bad = 0;
        for (int t = 1; t < 70; t++) begin
            @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
            exp_p = (t == 40 || t == 50 || t == 60);
`else
            exp_p = 1'b0;
`endif
            if (key_valid !== exp_p || key_code !== 4'hD) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL repeat_pattern: got %0d bad cycles expected 0", bad); end
        keys = '0;
        wait_held_low(80, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL repeat_release: got held expected released"); end
    endtask

    initial begin
        clk      = 1'b0;
        nrst     = 1'b1;
        keys     = '0;
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_two_keys();
        test_reset_mid_press();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
